// File: rtl/fsm_moore_tx.sv
// fsm_moore_tx: serial frame transmitter (Moore FSM, registered outputs).
// Accepts a parallel word on start/ready and shifts it out MSB first,
// then pulses done for one cycle. Optional 1,0,1,0 sync preamble ahead
// of the payload is compiled in with `define TX_PREAMBLE_EN.
module fsm_moore_tx #(
  parameter int   DATA_W     = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              outp,
  output logic              valid,
  output logic              ready,
  output logic              done
);

  localparam int            CW   = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     bcnt;
`ifdef TX_PREAMBLE_EN
  logic [1:0]        pcnt;
`endif

  // State, datapath and outputs all move together; each branch loads the
  // outputs that belong to the state being entered, so they are pure
  // functions of registered state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      sreg  <= '0;
      bcnt  <= '0;
`ifdef TX_PREAMBLE_EN
      pcnt  <= '0;
`endif
      outp  <= IDLE_LEVEL;
      valid <= 1'b0;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sreg  <= data;
            bcnt  <= '0;
            valid <= 1'b1;
            ready <= 1'b0;
            done  <= 1'b0;
`ifdef TX_PREAMBLE_EN
            state <= S_PRE;
            pcnt  <= '0;
            outp  <= 1'b1;            // first preamble bit
`else
            state <= S_DATA;
            outp  <= data[DATA_W-1];  // first payload bit, MSB
`endif
          end else begin
            outp  <= IDLE_LEVEL;
            valid <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
          end
        end
`ifdef TX_PREAMBLE_EN
        S_PRE: begin
          if (pcnt == 2'd3) begin
            state <= S_DATA;
            outp  <= sreg[DATA_W-1];
          end else begin
            pcnt <= pcnt + 2'd1;
            // Preamble bit at index i is ~i[0]; the next index has lsb
            // ~pcnt[0], so its bit is simply pcnt[0].
            outp <= pcnt[0];
          end
        end
`endif
        S_DATA: begin
          if (bcnt == LAST) begin
            state <= S_STOP;
            outp  <= IDLE_LEVEL;
            valid <= 1'b0;
            done  <= 1'b1;
          end else begin
            sreg <= {sreg[DATA_W-2:0], 1'b0};
            bcnt <= bcnt + CW'(1);
            outp <= sreg[DATA_W-2];   // bit that becomes MSB after the shift
          end
        end
        S_STOP: begin
          state <= S_IDLE;
          outp  <= IDLE_LEVEL;
          valid <= 1'b0;
          ready <= 1'b1;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          outp  <= IDLE_LEVEL;
          valid <= 1'b0;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_moore_tx.sv
// Bench for fsm_moore_tx: two instances (4-bit/idle 0, 8-bit/idle 1),
// a frame-position model checked every cycle, plus literal frame checks.
module tb_fsm_moore_tx;

`ifdef TX_PREAMBLE_EN
  localparam int P = 4;
`else
  localparam int P = 0;
`endif

  logic       clock, reset;
  logic       start0, start1;
  logic [3:0] data0;
  logic [7:0] data1;
  logic       o0, v0, r0, d0, o1, v1, r1, d1;

  fsm_moore_tx #(.DATA_W(4), .IDLE_LEVEL(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .data(data0),
    .outp(o0), .valid(v0), .ready(r0), .done(d0));

  fsm_moore_tx #(.DATA_W(8), .IDLE_LEVEL(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .data(data1),
    .outp(o1), .valid(v1), .ready(r1), .done(d1));

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected {outp,valid,ready,done} k cycles after the accepting edge (k=0: idle).
  function automatic logic [3:0] exp_at(input int k, input logic [15:0] d,
                                        input int w, input logic il);
    if (k == 0)     return {il, 1'b0, 1'b1, 1'b0};
    if (k <= P)     return {((k % 2) == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0};
    if (k <= P + w) return {d[w-1-(k-P-1)], 1'b1, 1'b0, 1'b0};
    return {il, 1'b0, 1'b0, 1'b1};
  endfunction

  // Model: position within the current frame, 0 when idle/ready.
  int pos0 = 0, pos1 = 0;
  logic [15:0] cap0 = '0, cap1 = '0;
  always @(posedge clock) begin
    if (reset) begin
      pos0 = 0; pos1 = 0;
    end else begin
      if (pos0 == 0) begin
        if (start0) begin pos0 = 1; cap0 = {12'b0, data0}; end
      end else begin
        pos0++;
        if (pos0 > P + 4 + 1) pos0 = 0;
      end
      if (pos1 == 0) begin
        if (start1) begin pos1 = 1; cap1 = {8'b0, data1}; end
      end else begin
        pos1++;
        if (pos1 > P + 8 + 1) pos1 = 0;
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("dut0_outputs", {28'b0, o0, v0, r0, d0}, {28'b0, exp_at(pos0, cap0, 4, 1'b0)});
      chk("dut1_outputs", {28'b0, o1, v1, r1, d1}, {28'b0, exp_at(pos1, cap1, 8, 1'b1)});
    end
  end

  task automatic next_cycle();
    @(posedge clock); #2;
  endtask

  // Send one frame on dut0, scrambling data after capture; record cycles 1..23.
  task automatic frame0(input logic [3:0] d, input logic hold,
                        output logic [23:0] ob, output logic [23:0] vb,
                        output logic [23:0] rb, output logic [23:0] db);
    ob = '0; vb = '0; rb = '0; db = '0;
    start0 = 1'b1; data0 = d;
    @(posedge clock); #2;
    start0 = hold;
    data0  = hold ? 4'b0000 : ~d;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clock);
      ob[c] = o0; vb[c] = v0; rb[c] = r0; db[c] = d0;
    end
    @(posedge clock); #2;
    start0 = 1'b0;
  endtask

  initial begin
    logic [23:0] ob, vb, rb, db;
    logic [7:0]  act;
    int          f;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; data0 = '0; data1 = '0;
    next_cycle();
    chk_en = 1'b1;
    next_cycle();
    reset = 1'b0;

    // Reset values
    @(negedge clock);
    chk("rst_dut0", {28'b0, o0, v0, r0, d0}, 32'b0010);
    chk("rst_dut1", {28'b0, o1, v1, r1, d1}, 32'b1010);
    next_cycle();

    // Basic frame, literal expectations
`ifdef TX_PREAMBLE_EN
    frame0(4'b0011, 1'b0, ob, vb, rb, db);
    act = '0; for (int c = 1; c <= 8; c++) act = {act[6:0], ob[c]};
    chk("pre_outp_seq", {24'b0, act}, 32'b10100011);
    act = '0; for (int c = 1; c <= 8; c++) act = {act[6:0], vb[c]};
    chk("pre_valid_seq", {24'b0, act}, 32'hff);
    chk("pre_stop_c9", {29'b0, ob[9], vb[9], db[9]}, 32'b001);
    chk("pre_ready_c9_c10", {30'b0, rb[9], rb[10]}, 32'b01);
`else
    frame0(4'b1010, 1'b0, ob, vb, rb, db);
    act = '0; for (int c = 1; c <= 4; c++) act = {act[6:0], ob[c]};
    chk("nopre_outp_seq", {24'b0, act}, 32'b1010);
    chk("nopre_done_c5", {30'b0, vb[5], db[5]}, 32'b01);
    chk("nopre_ready_c5_c6", {30'b0, rb[5], rb[6]}, 32'b01);
`endif

    // start held high: frames at 0 and F only, second carries new data
    f = P + 4 + 2;
    frame0(4'b1111, 1'b1, ob, vb, rb, db);
    chk("held_stop_before_idle", {30'b0, vb[f-1], db[f-1]}, 32'b01);
    chk("held_idle_cycle", {30'b0, vb[f], rb[f]}, 32'b01);
    chk("held_second_start", {31'b0, vb[f+1]}, 32'b1);
    act = '0; for (int c = P + 1; c <= P + 4; c++) act = {act[6:0], ob[c]};
    chk("held_frame1_data", {24'b0, act}, 32'b1111);
    act = '0; for (int c = f + P + 1; c <= f + P + 4; c++) act = {act[6:0], ob[c]};
    chk("held_frame2_data", {24'b0, act}, 32'b0000);
    repeat (2 * f) next_cycle();

    // Reset mid-frame, then a fresh frame
    start0 = 1'b1; data0 = 4'b0110;
    next_cycle();
    start0 = 1'b0;
    act = '0;
    for (int c = 1; c < P + 2; c++) begin
      @(negedge clock); act[0] = act[0] | d0;
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("abort_idle", {28'b0, o0, v0, r0, d0}, 32'b0010);
    chk("abort_no_done", {31'b0, act[0]}, 32'b0);
    next_cycle();
    frame0(4'b1001, 1'b0, ob, vb, rb, db);
    act = '0; for (int c = P + 1; c <= P + 4; c++) act = {act[6:0], ob[c]};
    chk("after_abort_data", {24'b0, act}, 32'b1001);
    chk("after_abort_done", {31'b0, db[P+5]}, 32'b1);

    // reset and start on the same edge: not accepted
    reset = 1'b1; start0 = 1'b1; start1 = 1'b1; data0 = 4'hf; data1 = 8'hff;
    next_cycle();
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
    @(negedge clock);
    chk("rst_start_dut0", {29'b0, v0, r0, d0}, 32'b010);
    chk("rst_start_dut1", {29'b0, v1, r1, d1}, 32'b010);
    next_cycle();

    // IDLE_LEVEL=1, DATA_W=8, data A5
    @(negedge clock);
    chk("w8_idle_level", {31'b0, o1}, 32'b1);
    next_cycle();
    start1 = 1'b1; data1 = 8'hA5;
    next_cycle();
    start1 = 1'b0; data1 = 8'h00;
    ob = '0; db = '0;
    for (int c = 1; c <= P + 10; c++) begin
      @(negedge clock); ob[c] = o1; db[c] = d1;
    end
    next_cycle();
    act = '0; for (int c = P + 1; c <= P + 8; c++) act = {act[6:0], ob[c]};
    chk("w8_payload", {24'b0, act}, 32'hA5);
    chk("w8_stop_level", {30'b0, ob[P+9], db[P+9]}, 32'b11);
    chk("w8_idle_after", {30'b0, ob[P+10], db[P+10]}, 32'b10);

    repeat (4) next_cycle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_moore_tx.md
# fsm_moore_tx

Serial frame transmitter, a Moore state machine and the transmit side of the serial pattern-detector link. It accepts a parallel word through a start/ready handshake. It shifts the word out one bit per clock, MSB first, optionally preceded by a fixed 1010 sync preamble. It then signals completion with a one-cycle done pulse. All outputs are functions of the registered state only; no input reaches an output combinationally.

## Interface
- DATA_W, default 4: payload width in bits; legal range 2..16.
- IDLE_LEVEL, default 1'b0: value driven on outp whenever no preamble or payload bit is being sent.
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; forces IDLE on the next rising edge.
- start  input  1  request to send a frame; sampled only while ready=1.
- data  input  DATA_W  payload word; captured on the same edge that accepts start.
- outp  output  1  serial bit stream.
- valid  output  1  high while outp carries a preamble or payload bit.
- ready  output  1  high only in IDLE; the block accepts start only then.
- done  output  1  one-cycle pulse in STOP, at the end of each frame.

## Operation
- States: IDLE, PRE, DATA, STOP.
  - Encoding is a 2-bit register.
  - Power-up initial value is IDLE.
  - Any unused or illegal encoding goes to IDLE on the next edge.
- IDLE
  - outp=IDLE_LEVEL, valid=0, ready=1, done=0.
  - When start=1 at an edge: capture data into the shift register, clear the bit counter, and go to PRE (to DATA if the preamble is compiled out).
  - When start=0: stay in IDLE.
- PRE
  - outp follows the fixed pattern 1,0,1,0 from a 2-bit preamble counter; valid=1, ready=0.
  - After the 4th bit, go to DATA.
- DATA
  - outp = shift register MSB; valid=1, ready=0.
  - Each edge shifts left by one and increments the bit counter (width $clog2(DATA_W)).
  - After bit DATA_W-1 is presented, go to STOP.
- STOP
  - outp=IDLE_LEVEL, valid=0, ready=0, done=1.
  - Go unconditionally to IDLE.
- start while ready=0 is ignored. It is not queued, and the data input is not sampled.
- Changes to the data input after capture have no effect on the frame in flight.
- Reset mid-frame: the next edge forces IDLE and clears the shift register and both counters.
  - From the cycle after that edge: outp=IDLE_LEVEL, valid=0, done=0, ready=1.
  - The aborted frame produces no done pulse.
- reset and start high on the same edge: reset wins and the frame is not accepted.

## Timing
- Cycle numbering: cycle 0 is the cycle in which start=1 is sampled in IDLE.
- With the preamble compiled in:
  - Preamble bits appear on cycles 1..4.
  - Payload bits appear on cycles 5..4+DATA_W.
  - STOP/done is on cycle 5+DATA_W.
  - ready returns on cycle 6+DATA_W.
- Without the preamble:
  - Payload bits appear on cycles 1..DATA_W.
  - done is on cycle DATA_W+1.
  - ready returns on cycle DATA_W+2.
- Latency from start acceptance to the first outp bit is 1 cycle.
- Minimum spacing between consecutive accepted starts is frame length + 1 cycle. IDLE always lasts at least one cycle.
- Output reset values: outp=IDLE_LEVEL, valid=0, ready=1, done=0.

## Configuration
- Macro TX_PREAMBLE_EN.
- When defined: the PRE state is present, and every frame starts with 1,0,1,0 so the detector on the far end can synchronise.
- When undefined:
  - The PRE state and the preamble counter are removed.
  - IDLE goes directly to DATA.
  - Frame length is DATA_W+1 cycles.

## Test plan
- Preamble on, DATA_W=4, data=4'b0011 with start pulsed at cycle 0:
  - outp = 1,0,1,0,0,0,1,1 on cycles 1..8 with valid=1.
  - Cycle 9: outp=0, valid=0, done=1.
  - Cycle 10: ready=1.
- Preamble off, DATA_W=4, data=4'b1010:
  - outp = 1,0,1,0 on cycles 1..4.
  - done=1 on cycle 5.
  - ready=1 on cycle 6.
- start held high continuously with data=4'b1111 then 4'b0000, preamble on:
  - Frames are accepted at cycles 0 and 10 only.
  - The second frame carries the data value present at cycle 10.
  - valid=0 on cycle 9, and also on cycle 10, which is the IDLE cycle.
- Reset asserted at cycle 6 of a frame:
  - From cycle 7: outp=IDLE_LEVEL, valid=0, ready=1.
  - No done pulse occurs.
  - A new start at cycle 8 produces a full, correct frame.
- reset and start both high at the same edge: the frame is not accepted, and ready stays 1 after that edge.
- IDLE_LEVEL=1, DATA_W=8, data=8'hA5: outp=1 in IDLE and STOP, and payload bits are 1,0,1,0,0,1,0,1.
